// File: rtl/pia_bus_if.sv
// pia_bus_if -- CPU-side bus of the PIA port B block.
//
// Signals:
//   n_cs   0 = CPU access to the PIA page (from the external page decoder)
//   r_w    1 = CPU read, 0 = CPU write
//   rs     register select (CPU A1:A0)
//   d_in   CPU write data
//   d_out  read data from the PIA
//   d_oe   1 = PIA drives d_out onto the CPU bus
//
// Transfer semantics: there is no valid/ready pair. The 6502 bus is a strobed
// bus: an access is present whenever n_cs=0. It completes unconditionally at
// the falling edge of o2, with no wait states. Writes commit at that edge.
// Read data is offered while o2 is high, which is when d_oe is asserted.
interface pia_bus_if;
    logic       n_cs;
    logic       r_w;
    logic [1:0] rs;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;

    modport master (output n_cs, output r_w, output rs, output d_in,
                    input d_out, input d_oe);
    modport slave  (input n_cs, input r_w, input rs, input d_in,
                    output d_out, output d_oe);
endinterface

// File: rtl/pia_portb.sv
// pia_portb -- port B half of a 6520/6821-style PIA.
//
// Provides ORB, DDRB and CRB with CB1 edge interrupt and CB2 manual output.
// The effective port value pb feeds the RAM expansion bank logic.
// All state changes on the falling edge of o2, which is when 6502 write data
// is valid.
//
// Ports:
//   o2      CPU phase-2 clock (active edge: falling)
//   n_rst   asynchronous active-low reset
//   bus     CPU bus (pia_bus_if.slave): n_cs, r_w, rs, d_in -> d_out, d_oe
//   cb1     CB1 input line
//   cb2     CB2 output (CRB[3] in manual-output mode, otherwise 1)
//   n_irqb  active-low port B interrupt
//   pb      effective PORTB value: (ORB & DDRB) | ~DDRB
module pia_portb (
    input  logic       o2,
    input  logic       n_rst,
    pia_bus_if.slave   bus,
    input  logic       cb1,
    output logic       cb2,
    output logic       n_irqb,
    output logic [7:0] pb
);

    logic [7:0] orb;
    logic [7:0] ddrb;
    logic [5:0] crb;
    logic       irqb1;
    logic       cb1_q;

    logic sel_orb;
    logic sel_ddrb;
    logic sel_crb;
    logic wr_en;
    logic rd_orb;
    logic cb1_active;

    // rs=01 is shared by ORB and DDRB; CRB[2] chooses between them.
    // rs=00/10 belong to port A and decode to nothing here.
    assign sel_orb  = (bus.rs == 2'b01) && crb[2];
    assign sel_ddrb = (bus.rs == 2'b01) && !crb[2];
    assign sel_crb  = (bus.rs == 2'b11);

    assign wr_en  = !bus.n_cs && !bus.r_w;
    assign rd_orb = !bus.n_cs && bus.r_w && sel_orb;

    // An active transition is a change on CB1 whose new level equals the
    // polarity bit CRB[1] (0 = falling edge, 1 = rising edge).
    assign cb1_active = (cb1_q != cb1) && (cb1 == crb[1]);

    always_ff @(negedge o2 or negedge n_rst) begin
        if (!n_rst) begin
            orb   <= 8'h00;
            ddrb  <= 8'h00;
            crb   <= 6'h00;
            irqb1 <= 1'b0;
            cb1_q <= 1'b1;
        end else begin
            cb1_q <= cb1;
            if (wr_en && sel_orb)  orb  <= bus.d_in;
            if (wr_en && sel_ddrb) ddrb <= bus.d_in;
            if (wr_en && sel_crb)  crb  <= bus.d_in[5:0];
            // A new edge arriving on the same cycle as the clearing ORB
            // read must not be lost, so set has priority.
            if (cb1_active)  irqb1 <= 1'b1;
            else if (rd_orb) irqb1 <= 1'b0;
        end
    end

    // Input-mode bits read as 1 (pull-ups).
    assign pb = (orb & ddrb) | ~ddrb;

    // Bus is driven only in the o2-high half of a read of a port B register.
    assign bus.d_oe = !bus.n_cs && bus.r_w && bus.rs[0] && o2;

    always_comb begin
        bus.d_out = 8'h00;
        if (sel_orb)       bus.d_out = pb;
        else if (sel_ddrb) bus.d_out = ddrb;
        else if (sel_crb)  bus.d_out = {irqb1, 1'b0, crb};
    end

    assign cb2    = (crb[5:4] == 2'b11) ? crb[3] : 1'b1;
    assign n_irqb = !(irqb1 && crb[0]);

endmodule

// File: tb/tb_pia_portb.sv
// tb_pia_portb -- directed bench for pia_portb with a queued scoreboard.
module tb_pia_portb;

    localparam int W = 8;

    localparam int K_PB    = 0;
    localparam int K_DOUT  = 1;
    localparam int K_DOE   = 2;
    localparam int K_NIRQB = 3;
    localparam int K_CB2   = 4;

    logic o2;
    logic n_rst;
    logic cb1;
    logic cb2;
    logic n_irqb;
    logic [7:0] pb;

    pia_bus_if bus ();

    pia_portb dut (
        .o2     (o2),
        .n_rst  (n_rst),
        .bus    (bus),
        .cb1    (cb1),
        .cb2    (cb2),
        .n_irqb (n_irqb),
        .pb     (pb)
    );

    // ---------------- clock / reset ----------------
    initial begin
        o2 = 1'b1;
        forever #10 o2 = ~o2;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           kind_q[$];
    string        name_q[$];
    int           total;
    int           bad;
    event         chk_ev;

    task automatic expect_val(input int kind, input logic [W-1:0] val, input string nm);
        exp_q.push_back(val);
        kind_q.push_back(kind);
        name_q.push_back(nm);
        -> chk_ev;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                logic [W-1:0] e;
                logic [W-1:0] act;
                int           k;
                string        nm;
                e   = exp_q.pop_front();
                k   = kind_q.pop_front();
                nm  = name_q.pop_front();
                act = '0;
                case (k)
                    K_PB:    act = pb;
                    K_DOUT:  act = bus.d_out;
                    K_DOE:   act = {7'd0, bus.d_oe};
                    K_NIRQB: act = {7'd0, n_irqb};
                    K_CB2:   act = {7'd0, cb2};
                    default: act = 'x;
                endcase
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_write(input logic [1:0] r, input logic [7:0] d);
        @(posedge o2);
        #1;
        bus.n_cs = 1'b0;
        bus.r_w  = 1'b0;
        bus.rs   = r;
        bus.d_in = d;
        @(negedge o2);
        #1;
        bus.n_cs = 1'b1;
        bus.r_w  = 1'b1;
    endtask

    // Checks d_oe and d_out during the o2-high half, then completes the
    // access at the falling edge.
    task automatic cpu_read(input logic [1:0] r, input logic [7:0] exp_d,
                            input logic exp_oe, input string nm);
        @(posedge o2);
        #1;
        bus.n_cs = 1'b0;
        bus.r_w  = 1'b1;
        bus.rs   = r;
        #2;
        expect_val(K_DOE, {7'd0, exp_oe}, {nm, "_oe"});
        expect_val(K_DOUT, exp_d, {nm, "_dout"});
        @(negedge o2);
        #1;
        bus.n_cs = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge o2);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_rst    = 1'b0;
        cb1      = 1'b1;
        bus.n_cs = 1'b1;
        bus.r_w  = 1'b1;
        bus.rs   = 2'b00;
        bus.d_in = 8'h00;

        // Reset held: a write of CRB=$30 across a falling edge must be ignored
        // (it would otherwise drive cb2 low).
        #3;
        expect_val(K_PB, 8'hFF, "rst_pb");
        expect_val(K_NIRQB, 8'h01, "rst_nirqb");
        expect_val(K_CB2, 8'h01, "rst_cb2");
        bus.n_cs = 1'b0;
        bus.r_w  = 1'b0;
        bus.rs   = 2'b11;
        bus.d_in = 8'h30;
        @(negedge o2);
        #1;
        expect_val(K_CB2, 8'h01, "rst_abort_cb2");
        expect_val(K_PB, 8'hFF, "rst_abort_pb");
        bus.n_cs = 1'b1;
        bus.r_w  = 1'b1;
        @(posedge o2);
        #1;
        n_rst = 1'b1;
        idle_cycle();

        // OS init sequence.
        cpu_write(2'b11, 8'h38);
        expect_val(K_CB2, 8'h01, "init_cb2_38");
        cpu_write(2'b01, 8'hFF);
        expect_val(K_PB, 8'h00, "init_ddrb_pb");
        cpu_write(2'b11, 8'h3C);
        cpu_write(2'b01, 8'hE3);
        expect_val(K_PB, 8'hE3, "init_pb");
        expect_val(K_CB2, 8'h01, "init_cb2");
        cpu_read(2'b11, 8'h3C, 1'b1, "init_crb");
        cpu_write(2'b11, 8'h34);
        expect_val(K_CB2, 8'h00, "cb2_manual_low");
        cpu_write(2'b11, 8'h3C);
        expect_val(K_CB2, 8'h01, "cb2_manual_high");
        cpu_write(2'b11, 8'h1C);
        expect_val(K_CB2, 8'h01, "cb2_not_manual");

        // Asynchronous reset with ORB=$E3, DDRB=$FF, no o2 edge in between.
        @(posedge o2);
        #1;
        n_rst = 1'b0;
        #2;
        expect_val(K_PB, 8'hFF, "rst2_pb");
        expect_val(K_NIRQB, 8'h01, "rst2_nirqb");
        expect_val(K_CB2, 8'h01, "rst2_cb2");
        #2;
        n_rst = 1'b1;
        idle_cycle();

        // Mixed direction.
        cpu_write(2'b01, 8'h0F);
        cpu_write(2'b11, 8'h04);
        cpu_write(2'b01, 8'h00);
        expect_val(K_PB, 8'hF0, "mixed_pb");
        cpu_read(2'b01, 8'hF0, 1'b1, "mixed_orb");
        // Same read, o2 low half: bus not driven.
        @(posedge o2);
        #1;
        bus.n_cs = 1'b0;
        bus.r_w  = 1'b1;
        bus.rs   = 2'b01;
        @(negedge o2);
        #1;
        expect_val(K_DOE, 8'h00, "oe_o2_low");
        bus.n_cs = 1'b1;

        // CRB[2] toggle preserves ORB/DDRB.
        cpu_write(2'b11, 8'h00);
        cpu_read(2'b01, 8'h0F, 1'b1, "toggle_ddrb");
        cpu_write(2'b11, 8'h04);
        expect_val(K_PB, 8'hF0, "toggle_pb");

        // Port A space.
        cpu_write(2'b00, 8'hAA);
        cpu_write(2'b10, 8'hAA);
        expect_val(K_PB, 8'hF0, "porta_pb");
        cpu_read(2'b00, 8'h00, 1'b0, "porta_rd0");
        cpu_read(2'b10, 8'h00, 1'b0, "porta_rd2");
        cpu_read(2'b11, 8'h04, 1'b1, "porta_crb");
        cpu_read(2'b01, 8'hF0, 1'b1, "porta_orb");

        // Interrupt, falling-edge mode.
        cpu_write(2'b11, 8'h05);
        expect_val(K_NIRQB, 8'h01, "irq_idle");
        cb1 = 1'b0;
        idle_cycle();
        expect_val(K_NIRQB, 8'h00, "irq_set");
        cpu_read(2'b11, 8'h85, 1'b1, "irq_crb");
        expect_val(K_NIRQB, 8'h00, "irq_crb_noclr");
        cpu_read(2'b01, 8'hF0, 1'b1, "irq_orb");
        expect_val(K_NIRQB, 8'h01, "irq_cleared");
        cb1 = 1'b1;
        idle_cycle();
        expect_val(K_NIRQB, 8'h01, "irq_wrong_edge");
        cb1 = 1'b0;
        idle_cycle();
        expect_val(K_NIRQB, 8'h00, "irq_set2");
        cpu_write(2'b11, 8'h04);
        expect_val(K_NIRQB, 8'h01, "irq_masked");
        cpu_read(2'b11, 8'h84, 1'b1, "irq_mask_crb");

        // Simultaneous set and clear.
        cpu_write(2'b11, 8'h05);
        expect_val(K_NIRQB, 8'h00, "sim_unmask");
        cpu_read(2'b01, 8'hF0, 1'b1, "sim_clr");
        expect_val(K_NIRQB, 8'h01, "sim_cleared");
        cb1 = 1'b1;
        idle_cycle();
        cb1 = 1'b0;
        cpu_read(2'b01, 8'hF0, 1'b1, "sim_rd");
        expect_val(K_NIRQB, 8'h00, "sim_set_wins");

        // Rising-edge mode.
        cpu_write(2'b11, 8'h07);
        cpu_read(2'b01, 8'hF0, 1'b1, "rise_clr");
        expect_val(K_NIRQB, 8'h01, "rise_cleared");
        cb1 = 1'b1;
        idle_cycle();
        expect_val(K_NIRQB, 8'h00, "rise_set");

        // ---------------- report ----------------
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
